// File: rtl/tdisp_pkg.sv
// Shared glyphs and types for the temperature seven-segment scanner.
// Glyphs are active-low {g,f,e,d,c,b,a}.
package tdisp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_E     = 7'h06;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  typedef struct packed {
    logic       sign;
    logic [3:0] thou;
    logic [3:0] hund;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       c_f;
  } tdisp_val_t;

  typedef logic [2:0] tdisp_idx_t;

endpackage

// File: rtl/tdisp_sevenseg_scan_if.sv
// Value-in / display-out bundle of the seven-segment scanner.
interface tdisp_sevenseg_scan_if;

  logic       load;
  logic       sign;
  logic [3:0] thou;
  logic [3:0] hund;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       c_f;
  logic       blank;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       pending;

  modport master (
    output load, sign, thou, hund, tens, ones, c_f, blank,
    input  an, seg, dp, pending
  );

  modport slave (
    input  load, sign, thou, hund, tens, ones, c_f, blank,
    output an, seg, dp, pending
  );

endinterface

// File: rtl/bcd7seg.sv
// BCD digit to active-low seven-segment glyph; codes above 9 render as 'E'.
module bcd7seg
  import tdisp_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = SEG_E;
        case (digit)
            4'd0: glyph = SEG_DIGIT[0];
            4'd1: glyph = SEG_DIGIT[1];
            4'd2: glyph = SEG_DIGIT[2];
            4'd3: glyph = SEG_DIGIT[3];
            4'd4: glyph = SEG_DIGIT[4];
            4'd5: glyph = SEG_DIGIT[5];
            4'd6: glyph = SEG_DIGIT[6];
            4'd7: glyph = SEG_DIGIT[7];
            4'd8: glyph = SEG_DIGIT[8];
            4'd9: glyph = SEG_DIGIT[9];
            default: glyph = SEG_E;
        endcase
    end

endmodule

// File: rtl/tdisp_sevenseg_scan.sv
// Double-buffered, time-multiplexed 8-digit temperature display driver.
// New values are only promoted to the shown buffer at a frame boundary.
module tdisp_sevenseg_scan
  import tdisp_pkg::*;
#(
    parameter int unsigned DWELL = 100_000,
    parameter int unsigned NDIG  = 8
) (
    input logic           clk,
    input logic           rst_n,
    tdisp_sevenseg_scan_if.slave bus
);

    localparam int unsigned CntW    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam tdisp_idx_t  LastIdx = tdisp_idx_t'(NDIG - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    tdisp_idx_t      idx_q, idx_d;
    tdisp_val_t      pend_q, pend_d;
    tdisp_val_t      act_q, act_d;
    logic            pending_q, pending_d;
    logic [7:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;

    logic            tick;
    logic            frame_end;
    logic [3:0]      cur_digit;
    logic [6:0]      cur_glyph;
    tdisp_idx_t      hi_pos;
    logic            show_minus;

    assign tick      = (cnt_q == CntW'(DWELL - 1));
    assign frame_end = tick && (idx_q == LastIdx);

    always_comb begin
        cnt_d     = tick ? '0 : cnt_q + CntW'(1);
        idx_d     = idx_q;
        act_d     = act_q;
        pend_d    = pend_q;
        pending_d = pending_q;
        if (tick) begin
            idx_d = (idx_q == LastIdx) ? '0 : idx_q + 3'd1;
        end
        if (frame_end && pending_q) begin
            act_d     = pend_q;
            pending_d = 1'b0;
        end
        // A load on the boundary cycle still wins the pending slot.
        if (bus.load) begin
            pend_d    = '{sign: bus.sign, thou: bus.thou, hund: bus.hund,
                          tens: bus.tens, ones: bus.ones, c_f: bus.c_f};
            pending_d = 1'b1;
        end
    end

    always_comb begin
        cur_digit = 4'd0;
        case (idx_q)
            3'd0:    cur_digit = act_q.ones;
            3'd1:    cur_digit = act_q.tens;
            3'd2:    cur_digit = act_q.hund;
            3'd3:    cur_digit = act_q.thou;
            default: cur_digit = 4'd0;
        endcase
    end

    bcd7seg u_bcd7seg (
        .digit (cur_digit),
        .glyph (cur_glyph)
    );

    // Highest value digit that is lit; tens and ones are never blanked.
    always_comb begin
        hi_pos = 3'd1;
        if (act_q.hund != 4'd0) hi_pos = 3'd2;
        if (act_q.thou != 4'd0) hi_pos = 3'd3;
    end

    assign show_minus = act_q.sign &&
                        ({act_q.thou, act_q.hund, act_q.tens, act_q.ones} != 16'd0);

    always_comb begin
        seg_d = cur_glyph;
        if (idx_q == 3'd7) begin
            seg_d = act_q.c_f ? SEG_F : SEG_C;
        end else if (show_minus && (idx_q == hi_pos + 3'd1)) begin
            seg_d = SEG_MINUS;
        end else if (idx_q > hi_pos) begin
            seg_d = SEG_BLANK;
        end
        an_d = bus.blank ? 8'hFF : ~(8'd1 << idx_q);
        dp_d = (idx_q != 3'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            pend_q    <= '0;
            act_q     <= '0;
            pending_q <= 1'b0;
            an_q      <= 8'hFF;
            seg_q     <= SEG_BLANK;
            dp_q      <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pend_q    <= pend_d;
            act_q     <= act_d;
            pending_q <= pending_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
        end
    end

    assign bus.an      = an_q;
    assign bus.seg     = seg_q;
    assign bus.dp      = dp_q;
    assign bus.pending = pending_q;

endmodule

// File: tb/tb_tdisp_sevenseg_scan.sv
// Bench for tdisp_sevenseg_scan: cycle-count display model checked every cycle,
// plus directed frames with literal glyph expectations.
module tb_tdisp_sevenseg_scan;
    import tdisp_pkg::*;

    localparam int unsigned DW    = 4;
    localparam int FRAME = 8 * DW;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    tdisp_sevenseg_scan_if bus ();

    tdisp_sevenseg_scan #(
        .DWELL (DW),
        .NDIG  (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h06;
        endcase
    endfunction

    // What digit position pos shows for value v, from the layout rules.
    function automatic logic [6:0] model_seg(input tdisp_val_t v, input int pos);
        logic [3:0] dig [4];
        int top;
        dig[0] = v.ones; dig[1] = v.tens; dig[2] = v.hund; dig[3] = v.thou;
        top = 1;
        if (v.hund != 0) top = 2;
        if (v.thou != 0) top = 3;
        if (pos == 7) return v.c_f ? 7'h0E : 7'h46;
        if (v.sign && ({v.thou, v.hund, v.tens, v.ones} != 16'd0) && pos == top + 1)
            return 7'h3F;
        if (pos <= top) return glyph(dig[pos]);
        return 7'h7F;
    endfunction

    // Model: time since reset alone decides the scan position.
    int          m_cnt;
    logic        m_live = 1'b0;
    logic        m_pend;
    tdisp_val_t  m_pend_val, m_act;
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_live     <= 1'b1;
            m_cnt      <= 0;
            m_pend     <= 1'b0;
            m_pend_val <= '0;
            m_act      <= '0;
            e_an       <= 8'hFF;
            e_seg      <= 7'h7F;
            e_dp       <= 1'b1;
        end else begin
            e_an  <= bus.blank ? 8'hFF : ~(8'd1 << (m_cnt / DW));
            e_seg <= model_seg(m_act, m_cnt / DW);
            e_dp  <= ((m_cnt / DW) != 1);
            if (m_cnt == FRAME - 1 && m_pend) m_act <= m_pend_val;
            if (bus.load) begin
                m_pend_val <= {bus.sign, bus.thou, bus.hund, bus.tens, bus.ones, bus.c_f};
                m_pend     <= 1'b1;
            end else if (m_cnt == FRAME - 1) begin
                m_pend <= 1'b0;
            end
            m_cnt <= (m_cnt + 1) % FRAME;
        end
    end

    always @(negedge clk) begin
        if (m_live && rst_n) begin
            cmp("model_an", 32'(bus.an), 32'(e_an));
            cmp("model_seg", 32'(bus.seg), 32'(e_seg));
            cmp("model_dp", 32'(bus.dp), 32'(e_dp));
            cmp("model_pending", 32'(bus.pending), 32'(m_pend));
        end
    end

    task automatic wait_an(input logic [7:0] target);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.an !== target && n < 200);
        if (bus.an !== target) cmp("wait_an_timeout", 32'(bus.an), 32'(target));
    endtask

    task automatic check_digit(input int pos, input logic [6:0] s, input string nm);
        wait_an(~(8'd1 << pos));
        cmp($sformatf("%s_d%0d_seg", nm, pos), 32'(bus.seg), 32'(s));
        cmp($sformatf("%s_d%0d_dp", nm, pos), 32'(bus.dp), 32'(pos != 1));
    endtask

    // g = {d7, d6, ..., d0}
    task automatic check_frame(input logic [55:0] g, input string nm);
        for (int p = 0; p < 8; p++) check_digit(p, g[p*7 +: 7], nm);
    endtask

    task automatic load_val(input logic s, input logic [3:0] th, input logic [3:0] hu,
                            input logic [3:0] te, input logic [3:0] on, input logic cf);
        bus.sign = s; bus.thou = th; bus.hund = hu; bus.tens = te; bus.ones = on;
        bus.c_f = cf; bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    localparam logic [55:0] FR_ZERO_C = {7'h46, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.load = 1'b0; bus.sign = 1'b0; bus.thou = '0; bus.hund = '0;
        bus.tens = '0; bus.ones = '0; bus.c_f = 1'b0; bus.blank = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        cmp("rst_an", 32'(bus.an), 32'h0FF);
        cmp("rst_seg", 32'(bus.seg), 32'h07F);
        cmp("rst_dp", 32'(bus.dp), 32'd1);
        cmp("rst_pending", 32'(bus.pending), 32'd0);
        rst_n = 1'b1;

        // 1: power-up frame "0.0 C"
        check_frame(FR_ZERO_C, "t1");
        cmp("t1_pending", 32'(bus.pending), 32'd0);

        // 2: -25.7 C loaded mid-frame, shown from the next frame
        wait_an(8'hF7);
        load_val(1'b1, 4'd0, 4'd2, 4'd5, 4'd7, 1'b0);
        cmp("t2_pending_set", 32'(bus.pending), 32'd1);
        check_digit(4, 7'h7F, "t2_old");
        check_digit(7, 7'h46, "t2_old");
        check_frame({7'h46, 7'h7F, 7'h7F, 7'h7F, 7'h3F, 7'h24, 7'h12, 7'h78}, "t2");
        cmp("t2_pending_clr", 32'(bus.pending), 32'd0);

        // 3: -123.4 F
        wait_an(8'hFB);
        load_val(1'b1, 4'd1, 4'd2, 4'd3, 4'd4, 1'b1);
        check_frame({7'h0E, 7'h7F, 7'h7F, 7'h3F, 7'h79, 7'h24, 7'h30, 7'h19}, "t3");

        // 4: negative zero shows no minus
        wait_an(8'hFB);
        load_val(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        check_frame(FR_ZERO_C, "t4");

        // 5: last load in a frame wins; a boundary-cycle load waits one frame
        wait_an(8'hFD);
        load_val(1'b0, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
        load_val(1'b0, 4'd0, 4'd0, 4'd5, 4'd6, 1'b0);
        wait_an(8'h7F);
        repeat (DW - 2) @(negedge clk);
        load_val(1'b1, 4'd0, 4'hA, 4'd8, 4'd7, 1'b1);
        cmp("t5_pending_kept", 32'(bus.pending), 32'd1);
        check_frame({7'h46, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12, 7'h02}, "t5a");
        check_frame({7'h0E, 7'h7F, 7'h7F, 7'h7F, 7'h3F, 7'h06, 7'h00, 7'h78}, "t5b");
        cmp("t5_pending_clr", 32'(bus.pending), 32'd0);

        // 6: blanking, then asynchronous reset mid-frame
        wait_an(8'hF7);
        bus.blank = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cmp("t6_blank_an", 32'(bus.an), 32'h0FF);
        end
        bus.blank = 1'b0;
        check_frame({7'h0E, 7'h7F, 7'h7F, 7'h7F, 7'h3F, 7'h06, 7'h00, 7'h78}, "t6_after");

        wait_an(8'hFB);
        load_val(1'b0, 4'd0, 4'd1, 4'd1, 4'd1, 1'b0);
        cmp("t6_pending_set", 32'(bus.pending), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        cmp("t6_rst_an", 32'(bus.an), 32'h0FF);
        cmp("t6_rst_pending", 32'(bus.pending), 32'd0);
        cmp("t6_rst_seg", 32'(bus.seg), 32'h07F);
        cmp("t6_rst_dp", 32'(bus.dp), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        check_frame(FR_ZERO_C, "t6_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
